// File: rtl/ps2_key_decoder_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : ps2_key_decoder_if
//  Brief    : Byte-strobe input and held-key output bundle of ps2_key_decoder.
//  Revision : 1.0 - initial release
// ============================================================================
interface ps2_key_decoder_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_error;
    logic       key_space;
    logic       key_left;
    logic       key_right;
    logic       key_event;

    // master drives the received bytes, slave (the decoder) drives the keys
    modport master (
        output rx_data, rx_valid, rx_error,
        input  key_space, key_left, key_right, key_event
    );

    modport slave (
        input  rx_data, rx_valid, rx_error,
        output key_space, key_left, key_right, key_event
    );
endinterface
`default_nettype wire

// File: rtl/ps2_key_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : ps2_key_decoder
//  Brief    : PS/2 scan-code stream to held space/left/right key levels.
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 40000,
    parameter int PAUSE_LEN      = 7
) (
    input  logic               clk,
    input  logic               rst,
    ps2_key_decoder_if.slave   bus
);

    localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int c_SW = $clog2(PAUSE_LEN + 1);

    localparam logic [c_TW-1:0] c_TMO_LAST  = c_TW'(TIMEOUT_CYCLES - 1);
    localparam logic [c_SW-1:0] c_SKIP_LOAD = c_SW'(PAUSE_LEN);

    localparam logic [2:0] c_S_IDLE    = 3'd0;
    localparam logic [2:0] c_S_EXT     = 3'd1;
    localparam logic [2:0] c_S_BRK     = 3'd2;
    localparam logic [2:0] c_S_EXT_BRK = 3'd3;
    localparam logic [2:0] c_S_SKIP    = 3'd4;

    localparam logic c_DIR_LEFT  = 1'b0;
    localparam logic c_DIR_RIGHT = 1'b1;

    localparam logic [7:0] c_B_EXT   = 8'hE0;
    localparam logic [7:0] c_B_BRK   = 8'hF0;
    localparam logic [7:0] c_B_PAUSE = 8'hE1;

    logic [2:0]      r_state;
    logic [c_TW-1:0] r_tmo;
    logic [c_SW-1:0] r_skip;
    logic            r_sp;
    logic            r_la;
    logic            r_lk;
    logic            r_ra;
    logic            r_rk;
    logic            r_last_dir;
    logic            r_key_space;
    logic            r_key_left;
    logic            r_key_right;
    logic            r_key_event;

    logic [2:0]      w_state_nxt;
    logic [c_TW-1:0] w_tmo_nxt;
    logic [c_SW-1:0] w_skip_nxt;
    logic            w_make;
    logic            w_brk;
    logic            w_ext;
    logic            w_prefix;
    logic            w_housekeeping;
    logic            w_sp_nxt;
    logic            w_la_nxt;
    logic            w_lk_nxt;
    logic            w_ra_nxt;
    logic            w_rk_nxt;
    logic            w_dir_nxt;
    logic            w_left_raw;
    logic            w_right_raw;
    logic            w_key_space_nxt;
    logic            w_key_left_nxt;
    logic            w_key_right_nxt;
    logic            w_change;

    assign w_prefix       = (bus.rx_data == c_B_EXT) || (bus.rx_data == c_B_BRK);
    assign w_housekeeping = bus.rx_data inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};

    // Sequence tracking; rx_error outranks a coincident byte
    always_comb begin
        w_state_nxt = r_state;
        w_tmo_nxt   = r_tmo;
        w_skip_nxt  = r_skip;
        w_make      = 1'b0;
        w_brk       = 1'b0;
        w_ext       = 1'b0;
        if (bus.rx_error) begin
            w_state_nxt = c_S_IDLE;
            w_tmo_nxt   = '0;
            w_skip_nxt  = '0;
        end else if (bus.rx_valid) begin
            w_tmo_nxt = '0;
            case (r_state)
                c_S_IDLE: begin
                    if (bus.rx_data == c_B_EXT) begin
                        w_state_nxt = c_S_EXT;
                    end else if (bus.rx_data == c_B_BRK) begin
                        w_state_nxt = c_S_BRK;
                    end else if (bus.rx_data == c_B_PAUSE) begin
                        w_state_nxt = c_S_SKIP;
                        w_skip_nxt  = c_SKIP_LOAD;
                    end else if (!w_housekeeping) begin
                        w_make = 1'b1;
                    end
                end
                c_S_EXT: begin
                    if (bus.rx_data == c_B_BRK) begin
                        w_state_nxt = c_S_EXT_BRK;
                    end else if (bus.rx_data != c_B_EXT) begin
                        w_state_nxt = c_S_IDLE;
                        w_make      = 1'b1;
                        w_ext       = 1'b1;
                    end
                end
                c_S_BRK: begin
                    w_state_nxt = c_S_IDLE;
                    w_brk       = !w_prefix;
                end
                c_S_EXT_BRK: begin
                    w_state_nxt = c_S_IDLE;
                    w_brk       = !w_prefix;
                    w_ext       = 1'b1;
                end
                c_S_SKIP: begin
                    if (r_skip <= c_SW'(1)) begin
                        w_state_nxt = c_S_IDLE;
                        w_skip_nxt  = '0;
                    end else begin
                        w_skip_nxt = r_skip - c_SW'(1);
                    end
                end
                default: w_state_nxt = c_S_IDLE;
            endcase
        end else if (r_state != c_S_IDLE) begin
            if (r_tmo >= c_TMO_LAST) begin
                w_state_nxt = c_S_IDLE;
                w_tmo_nxt   = '0;
                w_skip_nxt  = '0;
            end else begin
                w_tmo_nxt = r_tmo + c_TW'(1);
            end
        end else begin
            w_tmo_nxt = '0;
        end
    end

    always_comb begin
        w_sp_nxt  = r_sp;
        w_la_nxt  = r_la;
        w_lk_nxt  = r_lk;
        w_ra_nxt  = r_ra;
        w_rk_nxt  = r_rk;
        w_dir_nxt = r_last_dir;
        if (w_make) begin
            case ({w_ext, bus.rx_data})
                {1'b0, 8'h29}: w_sp_nxt = 1'b1;
                {1'b0, 8'h1C}: begin w_lk_nxt = 1'b1; w_dir_nxt = c_DIR_LEFT;  end
                {1'b0, 8'h23}: begin w_rk_nxt = 1'b1; w_dir_nxt = c_DIR_RIGHT; end
                {1'b1, 8'h6B}: begin w_la_nxt = 1'b1; w_dir_nxt = c_DIR_LEFT;  end
                {1'b1, 8'h74}: begin w_ra_nxt = 1'b1; w_dir_nxt = c_DIR_RIGHT; end
                default: ;
            endcase
        end else if (w_brk) begin
            case ({w_ext, bus.rx_data})
                {1'b0, 8'h29}: w_sp_nxt = 1'b0;
                {1'b0, 8'h1C}: w_lk_nxt = 1'b0;
                {1'b0, 8'h23}: w_rk_nxt = 1'b0;
                {1'b1, 8'h6B}: w_la_nxt = 1'b0;
                {1'b1, 8'h74}: w_ra_nxt = 1'b0;
                default: ;
            endcase
        end
    end

    // Outputs are derived from next-state raw levels so they land one cycle after the strobe
    assign w_left_raw      = w_la_nxt | w_lk_nxt;
    assign w_right_raw     = w_ra_nxt | w_rk_nxt;
    assign w_key_space_nxt = w_sp_nxt;
    assign w_key_left_nxt  = w_left_raw  & (!w_right_raw || (w_dir_nxt == c_DIR_LEFT));
    assign w_key_right_nxt = w_right_raw & (!w_left_raw  || (w_dir_nxt == c_DIR_RIGHT));
    assign w_change        = (w_key_space_nxt != r_key_space) ||
                             (w_key_left_nxt  != r_key_left)  ||
                             (w_key_right_nxt != r_key_right);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_S_IDLE;
            r_tmo       <= '0;
            r_skip      <= '0;
            r_sp        <= 1'b0;
            r_la        <= 1'b0;
            r_lk        <= 1'b0;
            r_ra        <= 1'b0;
            r_rk        <= 1'b0;
            r_last_dir  <= c_DIR_LEFT;
            r_key_space <= 1'b0;
            r_key_left  <= 1'b0;
            r_key_right <= 1'b0;
            r_key_event <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tmo       <= w_tmo_nxt;
            r_skip      <= w_skip_nxt;
            r_sp        <= w_sp_nxt;
            r_la        <= w_la_nxt;
            r_lk        <= w_lk_nxt;
            r_ra        <= w_ra_nxt;
            r_rk        <= w_rk_nxt;
            r_last_dir  <= w_dir_nxt;
            r_key_space <= w_key_space_nxt;
            r_key_left  <= w_key_left_nxt;
            r_key_right <= w_key_right_nxt;
            r_key_event <= w_change;
        end
    end

    assign bus.key_space = r_key_space;
    assign bus.key_left  = r_key_left;
    assign bus.key_right = r_key_right;
    assign bus.key_event = r_key_event;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_ps2_key_decoder
//  Brief    : Scoreboard bench: expected key levels queued per byte, popped on key_event.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_key_decoder;

    typedef struct packed {
        logic [2:0]  keys;   // {space, left, right}
        logic [31:0] cyc;
    } exp_t;

    logic clk;
    logic rst;
    ps2_key_decoder_if bus_if ();

    ps2_key_decoder #(
        .TIMEOUT_CYCLES (40000),
        .PAUSE_LEN      (7)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    exp_t        exp_q[$];
    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    int unsigned n_evt   = 0;
    int unsigned n_unexp = 0;
    logic [31:0] cyc     = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: every key_event pops the oldest expectation
    always @(negedge clk) begin
        if (rst && bus_if.key_event === 1'b1) begin
            exp_t e;
            n_evt++;
            if (exp_q.size() == 0) begin
                n_unexp++;
            end else begin
                e = exp_q.pop_front();
                check("evt_keys", 32'({bus_if.key_space, bus_if.key_left, bus_if.key_right}), 32'(e.keys));
                check("evt_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic drive(input logic [7:0] b, input logic v, input logic e,
                         input logic has_exp, input logic [2:0] keys);
        @(negedge clk);
        if (has_exp) exp_q.push_back('{keys: keys, cyc: cyc + 1});
        bus_if.rx_data  = b;
        bus_if.rx_valid = v;
        bus_if.rx_error = e;
        @(negedge clk);
        bus_if.rx_valid = 1'b0;
        bus_if.rx_error = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        drive(b, 1'b1, 1'b0, 1'b0, 3'b000);
    endtask

    task automatic send_exp(input logic [7:0] b, input logic [2:0] keys);
        drive(b, 1'b1, 1'b0, 1'b1, keys);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_keys(input string name, input logic [2:0] keys);
        check(name, 32'({bus_if.key_space, bus_if.key_left, bus_if.key_right}), 32'(keys));
    endtask

    initial begin
        int unsigned ev0;
        logic [7:0] pause_seq [8];
        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

        rst             = 1'b0;
        bus_if.rx_data  = 8'h00;
        bus_if.rx_valid = 1'b0;
        bus_if.rx_error = 1'b0;
        idle(3);
        chk_keys("reset_keys", 3'b000);
        check("reset_event", 32'(bus_if.key_event), 32'd0);
        rst = 1'b1;
        idle(2);

        // space make, then break 100 cycles later
        ev0 = n_evt;
        send_exp(8'h29, 3'b100);
        idle(100);
        send(8'hF0);
        send_exp(8'h29, 3'b000);
        idle(5);
        check("space_evt_count", n_evt - ev0, 32'd2);
        chk_keys("space_released", 3'b000);

        // arrow left then 'A'; arrow released while 'A' still held
        ev0 = n_evt;
        send(8'hE0); send_exp(8'h6B, 3'b010);
        send(8'h1C);
        send(8'hE0); send(8'hF0); send(8'h6B);
        idle(5);
        chk_keys("left_held_by_A", 3'b010);
        check("left_evt_count", n_evt - ev0, 32'd1);
        send(8'hF0); send_exp(8'h1C, 3'b000);

        // both arrows: last pressed wins, release hands back
        send(8'hE0); send_exp(8'h6B, 3'b010);
        send(8'hE0); send_exp(8'h74, 3'b001);
        idle(3);
        chk_keys("right_wins", 3'b001);
        send(8'hE0); send(8'hF0); send_exp(8'h74, 3'b010);
        send(8'hE0); send(8'hF0); send_exp(8'h6B, 3'b000);

        // 'D' then 'A', then release both letters
        send_exp(8'h23, 3'b001);
        send_exp(8'h1C, 3'b010);
        send(8'hF0); send_exp(8'h1C, 3'b001);
        send(8'hF0); send_exp(8'h23, 3'b000);

        // unrecognised codes and housekeeping bytes
        send(8'h6B); send(8'h74); send(8'hAA); send(8'hFA);
        send(8'hE0); send(8'h29);
        send(8'hE0); send(8'h1C);
        idle(3);
        chk_keys("unrecognised", 3'b000);

        // break with a stray prefix is abandoned without a key change
        send_exp(8'h29, 3'b100);
        send(8'hF0); send(8'hE0); send(8'h29);
        idle(3);
        chk_keys("brk_proto_err", 3'b100);
        send(8'hF0); send_exp(8'h29, 3'b000);

        // E0 then timeout: 6B afterwards is a plain (ignored) make
        send(8'hE0);
        idle(40010);
        send(8'h6B);
        idle(3);
        chk_keys("timeout_6b", 3'b000);

        // Pause sequence swallowed, then space
        foreach (pause_seq[i]) send(pause_seq[i]);
        idle(3);
        chk_keys("pause_no_change", 3'b000);
        send_exp(8'h29, 3'b100);
        send(8'hF0); send_exp(8'h29, 3'b000);

        // exactly seven bytes follow E1; the eighth is decoded
        send(8'hE1);
        for (int i = 0; i < 6; i++) send(8'h29);
        send(8'h1C);
        send_exp(8'h23, 3'b001);
        send(8'hF0); send_exp(8'h23, 3'b000);

        // rx_error with a byte drops it; rx_error alone aborts a prefix
        drive(8'hF0, 1'b1, 1'b1, 1'b0, 3'b000);
        send_exp(8'h29, 3'b100);
        send(8'hE0);
        drive(8'h00, 1'b0, 1'b1, 1'b0, 3'b000);
        send_exp(8'h1C, 3'b110);
        idle(5);
        chk_keys("err_hold", 3'b110);

        // asynchronous reset mid-hold with a break prefix pending
        send(8'hF0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk_keys("async_reset_keys", 3'b000);
        check("async_reset_event", 32'(bus_if.key_event), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        send_exp(8'h29, 3'b100);
        send(8'hF0); send_exp(8'h29, 3'b000);

        idle(20);
        check("queue_drained", exp_q.size(), 32'd0);
        check("unexpected_events", n_unexp, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Converts the byte stream from the PS/2 keyboard receiver into the held key levels `key_space`, `key_left` and `key_right` consumed by `draw_rect_ctl`.
- Tracks the make, break and extended (E0) scan-code sequences.
- Resolves a simultaneous left+right hold so that only the last-pressed direction is reported.
- Discards the Pause sequence, keyboard housekeeping bytes and stale prefixes.

Parameters:
- `TIMEOUT_CYCLES`, 40000: clk cycles a partial prefix sequence may wait for its next byte before being abandoned (1 ms at 40 MHz).
- `PAUSE_LEN`, 7: number of bytes swallowed after an E1 byte (the rest of the Pause sequence).

Ports:
- `clk` input 1: system clock; all logic on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `rx_data` input 8: received scan-code byte; valid only while `rx_valid` = 1.
- `rx_valid` input 1: single-cycle strobe, one received byte.
- `rx_error` input 1: single-cycle strobe, framing/parity error on the current frame.
- `key_space` output 1: space held (make 29, break F0 29).
- `key_left` output 1: left direction active (raw keys: E0 6B arrow, or 1C 'A').
- `key_right` output 1: right direction active (raw keys: E0 74 arrow, or 23 'D').
- `key_event` output 1: one-cycle pulse when any of the three outputs changes value.

Behaviour:
- Reset (`rst` = 0, asynchronous):
  - FSM to IDLE; timeout and skip counters to 0.
  - All raw key registers, `key_*` outputs, the `last_dir` register and `key_event` to 0.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen), SKIP (Pause bytes).
- Transitions (only on `rx_valid` = 1):
  - IDLE:
    - E0 -> EXT.
    - F0 -> BRK.
    - E1 -> SKIP, skip counter loaded with `PAUSE_LEN`.
    - AA, FA, FE, EE, 00, FF -> ignored, stay in IDLE.
    - Any other byte -> make for that code, stay in IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> stay in EXT; any other byte -> extended make, go to IDLE.
  - BRK: any byte except E0/F0 -> break for that code, go to IDLE; E0 or F0 -> protocol error, go to IDLE, no key change.
  - EXT_BRK: any byte except E0/F0 -> extended break, go to IDLE; E0 or F0 -> go to IDLE, no key change.
  - SKIP: each byte decrements the skip counter; the FSM goes to IDLE on the byte that takes it to 0; no key change while in SKIP.
- Unrecognised make/break codes: no effect. Non-extended 6B/74 and extended 29/1C/23 are unrecognised.
- Raw registers:
  - `sp_raw`, `la_raw` (arrow), `lk_raw` ('A'), `ra_raw` (arrow), `rk_raw` ('D').
  - Make sets the register, break clears it; a repeated make (typematic) leaves it set.
  - `left_raw` = `la_raw` | `lk_raw`; `right_raw` = `ra_raw` | `rk_raw`.
- Direction resolution:
  - A make that sets a left source updates `last_dir` to LEFT; a make that sets a right source updates `last_dir` to RIGHT.
  - `key_left` = `left_raw` & (!`right_raw` | `last_dir` == LEFT).
  - `key_right` = `right_raw` & (!`left_raw` | `last_dir` == RIGHT).
  - Releasing the winning side hands over to the still-held side on the next cycle.
  - `key_space` = `sp_raw`.
- Latency:
  - Outputs are registered. The byte completing a sequence, strobed in cycle N, is reflected on `key_*` from cycle N+1.
  - `key_event` pulses in cycle N+1 only when some `key_*` output differs from its cycle-N value.
- Timeout:
  - In EXT, BRK, EXT_BRK or SKIP, the counter increments each cycle without `rx_valid` and clears on every `rx_valid`.
  - On reaching `TIMEOUT_CYCLES` the FSM returns to IDLE and the counter clears; key levels are unchanged.
  - In IDLE the counter is held at 0.
- `rx_error`:
  - Returns the FSM to IDLE and clears the counters; key levels are unchanged.
  - If `rx_error` and `rx_valid` are both high in the same cycle, `rx_error` wins and the byte is dropped.
- Reset mid-sequence: everything clears immediately; the byte after reset release is decoded from IDLE.
- Counter widths: `$clog2(TIMEOUT_CYCLES+1)` and `$clog2(PAUSE_LEN+1)`; no wrap (saturate at terminal count).

Test Plan:
- Bytes 29, then F0 29, 100 cycles apart -> `key_space` 0->1 the cycle after the 29 strobe, 1->0 the cycle after the second 29; `key_event` pulses exactly twice.
- E0 6B, then 1C, then E0 F0 6B -> `key_left` = 1 and stays 1 after the arrow break because 'A' is still held; `key_event` pulses once.
- E0 6B, then E0 74 -> `key_right` = 1 and `key_left` = 0. Then E0 F0 74 -> `key_left` = 1 the next cycle.
- E0, then no byte for 40000 cycles, then 6B -> the FSM times out to IDLE; 6B is a plain make with no effect; all keys stay 0.
- Pause sequence E1 14 77 E1 F0 14 F0 77, then 29 -> no key change during the sequence; `key_space` = 1 after the final 29.
- F0 strobed with `rx_error` = 1, then 29 -> the byte is dropped and 29 decodes as a make (`key_space` = 1). Assert `rst` = 0 mid-hold -> all outputs 0 asynchronously.
